// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the instruction-fetch slice.
//   XLEN_DEF / RESET_PC_DEF : default datapath width and boot address
//   PC_STEP                 : sequential fetch increment (one 32-bit word)
//   ifu_state_e             : fetch-unit state encoding
//   misaligned()            : true when an address is not word aligned
package cpu_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1,
      FULL  = 2'd2,
      FAULT = 2'd3
   } ifu_state_e;

   function automatic logic misaligned(input logic [1:0] lo);
      return (lo != 2'b00);
   endfunction

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction-fetch stage.
// Owns the fetch PC, issues word fetches over a variable-latency req/ack
// interface, holds the returned word for decode (valid/ready) and accepts
// redirects at any time, discarding wrong-path responses.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   redirect_valid/_pc        branch/jump redirect from execute
//   imem_req/_addr/_ack/_rdata instruction memory handshake
//   inst_valid/inst/inst_pc   held instruction to decode, inst_ready accepts
//   pc                        architectural next fetch address
// Optional feature (macro IFU_MISALIGN_CHECK_EN): adds fetch_fault and
// fault_pc; a misaligned fetch address parks the unit in FAULT instead of
// issuing a request, until the next redirect.
module ifu_fetch
   import cpu_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready,
`ifdef IFU_MISALIGN_CHECK_EN
   output logic            fetch_fault,
   output logic [XLEN-1:0] fault_pc,
`endif
   output logic [XLEN-1:0] pc
);

`ifdef IFU_MISALIGN_CHECK_EN
   localparam ifu_state_e RST_STATE = misaligned(RESET_PC[1:0]) ? FAULT : FETCH;
`else
   localparam ifu_state_e RST_STATE = FETCH;
`endif

   ifu_state_e      state_r, state_nxt_s;
   logic [XLEN-1:0] pc_r, pc_nxt_s;
   logic [XLEN-1:0] addr_r, addr_nxt_s;
   logic [XLEN-1:0] inst_r, inst_pc_r;
   logic            inst_valid_r;
   logic            req_r;
   logic            fault_r;
   logic            load_inst_s;

   // Next-state, next-PC and next-address selection for the fetch FSM.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      addr_nxt_s  = addr_r;
      load_inst_s = 1'b0;
      case (state_r)
         FETCH: begin
            if (imem_ack && redirect_valid) begin
               // Response is wrong-path; restart directly at the target.
               pc_nxt_s   = redirect_pc;
               addr_nxt_s = redirect_pc;
            end else if (imem_ack) begin
               load_inst_s = 1'b1;
               pc_nxt_s    = addr_r + XLEN'(PC_STEP);
               state_nxt_s = FULL;
            end else if (redirect_valid) begin
               // Request already in flight: keep addr stable, wait for its ack.
               pc_nxt_s    = redirect_pc;
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         DRAIN: begin
            if (imem_ack) begin
               pc_nxt_s    = redirect_valid ? redirect_pc : pc_r;
               addr_nxt_s  = redirect_valid ? redirect_pc : pc_r;
               state_nxt_s = FETCH;
            end else if (redirect_valid) begin
               pc_nxt_s = redirect_pc;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         FULL: begin
            if (redirect_valid) begin
               pc_nxt_s    = redirect_pc;
               addr_nxt_s  = redirect_pc;
               state_nxt_s = FETCH;
            end else if (inst_ready) begin
               addr_nxt_s  = pc_r;
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = FULL;
            end
         end
         FAULT: begin
            if (redirect_valid) begin
               pc_nxt_s    = redirect_pc;
               addr_nxt_s  = redirect_pc;
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = FAULT;
            end
         end
         default: begin
            state_nxt_s = FETCH;
         end
      endcase
`ifdef IFU_MISALIGN_CHECK_EN
      // Every entry into FETCH loads a new address; trap bad ones before a request.
      state_nxt_s = (state_nxt_s == FETCH && misaligned(addr_nxt_s[1:0])) ? FAULT : state_nxt_s;
`endif
   end

   // State, address and hold registers; output flags registered from next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= RST_STATE;
         pc_r         <= RESET_PC;
         addr_r       <= RESET_PC;
         inst_r       <= '0;
         inst_pc_r    <= '0;
         inst_valid_r <= 1'b0;
         req_r        <= (RST_STATE == FETCH);
         fault_r      <= (RST_STATE == FAULT);
      end else begin
         state_r      <= state_nxt_s;
         pc_r         <= pc_nxt_s;
         addr_r       <= addr_nxt_s;
         if (load_inst_s) begin
            inst_r    <= imem_rdata;
            inst_pc_r <= addr_r;
         end else begin
            inst_r    <= inst_r;
            inst_pc_r <= inst_pc_r;
         end
         inst_valid_r <= (state_nxt_s == FULL);
         req_r        <= (state_nxt_s == FETCH) || (state_nxt_s == DRAIN);
         fault_r      <= (state_nxt_s == FAULT);
      end
   end

   // Request is masked while rst is high so no fetch leaves during reset.
   assign imem_req   = req_r & ~rst;
   assign imem_addr  = addr_r;
   assign inst_valid = inst_valid_r;
   assign inst       = inst_r;
   assign inst_pc    = inst_pc_r;
   assign pc         = pc_r;
`ifdef IFU_MISALIGN_CHECK_EN
   assign fetch_fault = fault_r;
   assign fault_pc    = addr_r;
`else
   logic unused_fault_s;
   assign unused_fault_s = fault_r;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch -- directed self-checking bench for ifu_fetch (default build).
// A small memory responder acks after a programmable number of wait cycles
// and returns a known function of the address.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
   logic [31:0] pc;

   int          checks = 0;
   int          errors = 0;
   int          lat = 0;
   logic        mem_en = 1'b1;
   int          wait_cnt;

   ifu_fetch dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .pc(pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   assign imem_ack   = imem_req && mem_en && (wait_cnt >= lat);
   assign imem_rdata = mem_word(imem_addr);

   always_ff @(posedge clk) begin
      if (rst || !imem_req || imem_ack) wait_cnt <= 0;
      else                              wait_cnt <= wait_cnt + 1;
   end

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   // Holds reset for two cycles, then releases it mid-cycle.
   task automatic do_reset(input int lat_v, input logic ready_v);
      rst = 1'b1; redirect_valid = 1'b0; mem_en = 1'b1;
      lat = lat_v; inst_ready = ready_v;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; redirect_valid = 1'b0; mem_en = 1'b1; lat = 0; inst_ready = 1'b0;
      next_cycle();
      next_cycle();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
      checks++; if (inst_pc !== 32'h0 || inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h/%h exp 0/0", inst, inst_pc); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] a;
      do_reset(0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         a = 32'(i * 4);
         checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("FAIL zw_req got %b/%h exp 1/%h", imem_req, imem_addr, a); end
         checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL zw_gap got %b exp 0", inst_valid); end
         next_cycle();
         checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL zw_full got v%b r%b exp v1 r0", inst_valid, imem_req); end
         checks++; if (inst_pc !== a) begin errors++; $display("FAIL zw_inst_pc got %h exp %h", inst_pc, a); end
         checks++; if (inst !== mem_word(a)) begin errors++; $display("FAIL zw_inst got %h exp %h", inst, mem_word(a)); end
         checks++; if (pc !== a + 32'd4) begin errors++; $display("FAIL zw_pc got %h exp %h", pc, a + 32'd4); end
         next_cycle();
      end
   endtask

   task automatic test_latency();
      do_reset(3, 1'b0);
      for (int k = 0; k < 4; k++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL lat_req c%0d got %b/%h exp 1/0", k, imem_req, imem_addr); end
         checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL lat_valid c%0d got %b exp 0", k, inst_valid); end
         next_cycle();
      end
      for (int k = 0; k < 4; k++) begin
         checks++; if (inst_valid !== 1'b1 || inst !== mem_word(32'h0) || inst_pc !== 32'h0) begin
            errors++; $display("FAIL lat_hold c%0d got v%b %h/%h exp v1 %h/0", k, inst_valid, inst, inst_pc, mem_word(32'h0)); end
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL lat_noreq c%0d got %b exp 0", k, imem_req); end
         if (k == 3) inst_ready = 1'b1;
         next_cycle();
      end
      inst_ready = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || inst_valid !== 1'b0) begin
         errors++; $display("FAIL lat_next got r%b %h v%b exp r1 00000004 v0", imem_req, imem_addr, inst_valid); end
   endtask

   task automatic test_redirect_drain();
      do_reset(0, 1'b1);
      next_cycle();             // FULL @0
      next_cycle();             // FETCH @4
      next_cycle();             // FULL @4
      mem_en = 1'b0;
      next_cycle();             // FETCH @8, held off
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL dr_out got %b/%h exp 1/8", imem_req, imem_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      next_cycle();             // DRAIN
      redirect_valid = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL dr_hold got %b/%h exp 1/8", imem_req, imem_addr); end
      checks++; if (pc !== 32'h100 || inst_valid !== 1'b0) begin errors++; $display("FAIL dr_pc got %h v%b exp 100 v0", pc, inst_valid); end
      mem_en = 1'b1;
      next_cycle();             // FETCH @100
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
         errors++; $display("FAIL dr_new got r%b %h v%b exp r1 100 v0", imem_req, imem_addr, inst_valid); end
      next_cycle();             // FULL @100
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== mem_word(32'h100)) begin
         errors++; $display("FAIL dr_inst got v%b %h/%h exp v1 %h/100", inst_valid, inst, inst_pc, mem_word(32'h100)); end
   endtask

   task automatic test_redirect_full();
      do_reset(0, 1'b0);
      next_cycle();             // FULL @0
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rf_full got %b exp 1", inst_valid); end
      redirect_valid = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
      next_cycle();
      redirect_valid = 1'b0; inst_ready = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rf_drop got %b exp 0", inst_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || pc !== 32'h40) begin
         errors++; $display("FAIL rf_addr got r%b %h pc %h exp r1 40 pc 40", imem_req, imem_addr, pc); end
      next_cycle();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin errors++; $display("FAIL rf_inst got v%b %h exp v1 40", inst_valid, inst_pc); end
   endtask

   task automatic test_wrap();
      do_reset(0, 1'b0);
      next_cycle();             // FULL @0
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      next_cycle();             // FETCH @FFFFFFFC
      redirect_valid = 1'b0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr got %h exp fffffffc", imem_addr); end
      next_cycle();             // FULL
      checks++; if (inst_pc !== 32'hFFFF_FFFC || pc !== 32'h0) begin errors++; $display("FAIL wr_pc got %h/%h exp fffffffc/0", inst_pc, pc); end
      inst_ready = 1'b1;
      next_cycle();
      inst_ready = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wr_next got %b/%h exp 1/0", imem_req, imem_addr); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_latency();
      test_redirect_drain();
      test_redirect_full();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout after %0d checks", checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage that sits directly downstream of the program counter.
- Owns the fetch PC and issues requests to instruction memory over a req/ack handshake that tolerates variable latency.
- Holds the returned word and presents it to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute at any time; wrong-path fetches are discarded.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  XLEN  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address.
- imem_ack  in  1  response valid; imem_rdata is valid in the same cycle.
- imem_rdata  in  XLEN  fetched word.
- inst_valid  out  1  held instruction valid to decode.
- inst  out  XLEN  held instruction.
- inst_pc  out  XLEN  address of the held instruction.
- inst_ready  in  1  decode accepts the instruction.
- pc  out  XLEN  next fetch address (architectural fetch PC).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled at the posedge and dominates all other inputs.
- Reset values:
  - state is FETCH; pc and the address register are RESET_PC.
  - inst_valid, inst and inst_pc are 0.
  - imem_req is 0 during any cycle in which rst is high.
  - The first request is issued in the first cycle after rst falls.
- Reset mid-operation: any outstanding memory transaction is abandoned. Instruction memory shares rst, so no stale ack arrives after reset.
- Address register (addr_q) drives imem_addr. It is loaded only when entering or re-entering FETCH, and stays stable from the start of a request until its ack.
- FETCH state: imem_req is 1.
  - ack with no redirect: inst <= imem_rdata, inst_pc <= addr_q, pc <= addr_q + 4, go to FULL.
  - ack with redirect in the same cycle: discard imem_rdata; pc and addr_q <= redirect_pc; stay in FETCH. A new request starts next cycle.
  - redirect with no ack: pc <= redirect_pc; go to DRAIN; addr_q is unchanged.
  - neither: hold.
- DRAIN state: imem_req stays 1 at the old address.
  - Further redirects overwrite pc; the latest one wins.
  - On ack, discard the data, set addr_q <= pc, and go to FETCH.
  - An ack and a redirect in the same cycle use redirect_pc as the new address.
- FULL state: imem_req is 0 and inst_valid is 1.
  - Redirect takes priority over inst_ready: drop the held instruction (inst_valid is 0 next cycle), pc and addr_q <= redirect_pc, go to FETCH.
  - inst_ready with no redirect: addr_q <= pc, go to FETCH.
  - Otherwise hold inst and inst_pc stable.
- Latency and throughput:
  - With a 0-wait memory (ack in the same cycle as req), throughput is 1 instruction per 2 cycles.
  - The instruction is visible to decode the cycle after its ack.
- Arithmetic: pc + 4 is taken modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0. Redirect targets are used unmodified.
- inst_valid is 0 in every state except FULL. inst and inst_pc may hold stale values while inst_valid is 0.

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- When defined:
  - Adds output fetch_fault (1 bit) and output fault_pc (XLEN bits).
  - Before any request is issued, if addr_q[1:0] != 0 the block issues no request and enters FAULT.
  - In FAULT: fetch_fault is 1, fault_pc holds the bad address, imem_req is 0 and inst_valid is 0.
  - FAULT exits only on a redirect (to FETCH, or back to FAULT if the new target is also misaligned) or on rst.
- When undefined: no such ports exist, and low address bits pass to imem_addr unchecked.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN and RESET_PC defaults;
  - the ifu state encoding (FETCH, DRAIN, FULL, FAULT);
  - the PC_STEP constant, value 4.
- The design is flat with no sub-module. The state machine, address register and hold register fit in one module.

Test Plan:
- Reset then 0-wait memory → imem_addr sequence 0x0, 0x4, 0x8 on successive requests; inst_pc follows the same sequence; inst_valid toggles with a 1-cycle gap.
- 3-cycle ack latency plus inst_ready held low for 4 cycles → imem_addr stays stable until ack; inst stays stable while FULL; no new request is issued until ready.
- Redirect to 0x100 while a request to 0x8 is outstanding → DRAIN; the 0x8 data is never presented; next imem_addr is 0x100; inst_pc is 0x100.
- Redirect and inst_ready in the same cycle in FULL → held instruction dropped; next fetch is at the redirect target, not at inst_pc + 4.
- Redirect to 0xFFFF_FFFC → the fetch after it is at 0x0.
- With IFU_MISALIGN_CHECK_EN, redirect to 0x102 → fetch_fault = 1 and fault_pc = 0x102 with no imem_req; a later redirect to 0x200 resumes fetching.
